// File: rtl/pulse_tx_pkg.sv
// Shared definitions for the multi-channel pulse transmitter: FSM encoding,
// sym_data field layout helpers and parameter range limits.
package pulse_tx_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    localparam int NUM_CH_MIN     = 1;
    localparam int NUM_CH_MAX     = 8;
    localparam int DUR_W_MIN      = 4;
    localparam int DUR_W_MAX      = 16;
    localparam int FIFO_DEPTH_MIN = 2;
    localparam int FIFO_DEPTH_MAX = 32;

    // sym_data = {last, levels[NUM_CH-1:0], duration[DUR_W-1:0]}
    function automatic int sym_width(input int num_ch, input int dur_w);
        return num_ch + dur_w + 1;
    endfunction

    function automatic int dur_lsb(input int num_ch, input int dur_w);
        return (num_ch + dur_w) * 0;
    endfunction

    function automatic int level_lsb(input int num_ch, input int dur_w);
        return dur_w + (num_ch * 0);
    endfunction

    function automatic int last_bit(input int num_ch, input int dur_w);
        return num_ch + dur_w;
    endfunction

endpackage

// File: rtl/pulse_tx_symbol_fifo.sv
// First-word-fall-through symbol FIFO with push, pop, flush and occupancy count.
// A push while full is accepted only when a pop happens on the same edge.
module pulse_tx_symbol_fifo #(
    parameter int WIDTH = 19,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr_reg;
    logic [AW-1:0]    rd_ptr_reg;
    logic [AW:0]      count_reg;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_reg == (AW+1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign count   = count_reg;
    assign rd_data = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + AW'(1);
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + AW'(1);
            count_reg <= count_reg + (AW+1)'(do_push) - (AW+1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= wr_data;
    end

endmodule

// File: rtl/multi_pulse_transmitter.sv
// Multi-channel timed pulse transmitter fed from a symbol FIFO.
// Define PULSE_TX_CARRIER_EN to add carrier modulation on masked channels.
module multi_pulse_transmitter
    import pulse_tx_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int DUR_W      = 16,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [NUM_CH+DUR_W:0]         sym_data,
    input  logic                          sym_valid,
    output logic                          sym_ready,
    input  logic                          start,
    input  logic                          stop,
    input  logic                          flush,
    input  logic [7:0]                    cfg_prescaler,
    input  logic [NUM_CH-1:0]             cfg_idle_level,
    input  logic [NUM_CH-1:0]             cfg_invert,
    input  logic [15:0]                   cfg_carrier_half,
    input  logic [NUM_CH-1:0]             cfg_carrier_mask,
    output logic                          busy,
    output logic                          done,
    output logic                          underrun,
    input  logic                          underrun_clr,
    output logic [NUM_CH-1:0]             pulse_out,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

    localparam int SYM_W   = sym_width(NUM_CH, DUR_W);
    localparam int DUR_LSB = dur_lsb(NUM_CH, DUR_W);
    localparam int LVL_LSB = level_lsb(NUM_CH, DUR_W);
    localparam int LAST_B  = last_bit(NUM_CH, DUR_W);

    logic [SYM_W-1:0]  head;
    logic              full;
    logic              empty;
    logic              push;
    logic              load;

    state_t            state_reg, state_next;
    logic [NUM_CH-1:0] level_reg, level_next;
    logic              last_reg;
    logic [DUR_W-1:0]  dur_reg;
    logic [7:0]        pre_cnt_reg;
    logic [7:0]        presc_reg;
    logic              done_next;
    logic              underrun_set;
    logic              tick;
    logic              expire;
    logic [NUM_CH-1:0] mod_mask;
    logic [NUM_CH-1:0] pulse_next;

    // Accepting a push while full is safe only because the same edge pops.
    assign push       = sym_valid && (!full || load);
    assign sym_ready  = !full;
    assign busy       = (state_reg == RUN);

    pulse_tx_symbol_fifo #(
        .WIDTH (SYM_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .pop     (load),
        .flush   (flush),
        .wr_data (sym_data),
        .rd_data (head),
        .full    (full),
        .empty   (empty),
        .count   (fifo_count)
    );

    assign tick   = (pre_cnt_reg == presc_reg);
    assign expire = (state_reg == RUN) && tick && (dur_reg == '0);

    always_comb begin
        state_next   = state_reg;
        load         = 1'b0;
        done_next    = 1'b0;
        underrun_set = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start && !empty) begin
                    load       = 1'b1;
                    state_next = RUN;
                end
            end
            RUN: begin
                if (stop) begin
                    state_next = IDLE;
                end else if (expire) begin
                    if (last_reg) begin
                        state_next = IDLE;
                        done_next  = 1'b1;
                    end else if (!empty) begin
                        load = 1'b1;
                    end else begin
                        state_next   = IDLE;
                        underrun_set = 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
        level_next = load ? head[LVL_LSB +: NUM_CH] : level_reg;
    end

`ifdef PULSE_TX_CARRIER_EN
    logic              carrier_reg, carrier_next;
    logic [15:0]       ccnt_reg, ccnt_next;
    logic [15:0]       half_reg, half_next;
    logic [NUM_CH-1:0] mask_reg, mask_next;

    always_comb begin
        half_next = load ? cfg_carrier_half : half_reg;
        mask_next = load ? cfg_carrier_mask : mask_reg;
        if (state_next != RUN) begin
            carrier_next = 1'b0;
            ccnt_next    = '0;
        end else if (state_reg != RUN) begin
            carrier_next = 1'b1;
            ccnt_next    = '0;
        end else if (ccnt_reg == half_next) begin
            carrier_next = ~carrier_reg;
            ccnt_next    = '0;
        end else begin
            carrier_next = carrier_reg;
            ccnt_next    = ccnt_reg + 16'd1;
        end
        mod_mask = ~(mask_next & {NUM_CH{~carrier_next}});
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            carrier_reg <= 1'b0;
            ccnt_reg    <= '0;
            half_reg    <= '0;
            mask_reg    <= '0;
        end else begin
            carrier_reg <= carrier_next;
            ccnt_reg    <= ccnt_next;
            half_reg    <= half_next;
            mask_reg    <= mask_next;
        end
    end
`else
    logic unused_carrier_cfg;
    assign unused_carrier_cfg = ^{cfg_carrier_half, cfg_carrier_mask};
    assign mod_mask = '1;
`endif

    // Output is computed from next-state values so it changes on the load edge.
    assign pulse_next = ((state_next == RUN) ? (level_next & mod_mask) : cfg_idle_level)
                        ^ cfg_invert;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= IDLE;
            level_reg   <= '0;
            last_reg    <= 1'b0;
            dur_reg     <= '0;
            pre_cnt_reg <= '0;
            presc_reg   <= '0;
            done        <= 1'b0;
            underrun    <= 1'b0;
            pulse_out   <= '0;
        end else begin
            state_reg <= state_next;
            level_reg <= level_next;
            done      <= done_next;
            pulse_out <= pulse_next;
            if (load) begin
                last_reg    <= head[LAST_B];
                dur_reg     <= head[DUR_LSB +: DUR_W];
                pre_cnt_reg <= '0;
                presc_reg   <= cfg_prescaler;
            end else if (state_reg == RUN) begin
                if (tick) begin
                    pre_cnt_reg <= '0;
                    if (dur_reg != '0) dur_reg <= dur_reg - DUR_W'(1);
                end else begin
                    pre_cnt_reg <= pre_cnt_reg + 8'd1;
                end
            end
            if (underrun_set)      underrun <= 1'b1;
            else if (underrun_clr) underrun <= 1'b0;
        end
    end

endmodule

// File: tb/tb_multi_pulse_transmitter.sv
// Directed self-checking bench for multi_pulse_transmitter (default parameters).
// Carrier expectations follow PULSE_TX_CARRIER_EN when it is defined.
module tb_multi_pulse_transmitter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [18:0] sym_data;
    logic        sym_valid;
    logic        sym_ready;
    logic        start, stop, flush;
    logic [7:0]  cfg_prescaler;
    logic [1:0]  cfg_idle_level, cfg_invert;
    logic [15:0] cfg_carrier_half;
    logic [1:0]  cfg_carrier_mask;
    logic        busy, done, underrun, underrun_clr;
    logic [1:0]  pulse_out;
    logic [3:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    multi_pulse_transmitter #(
        .NUM_CH     (2),
        .DUR_W      (16),
        .FIFO_DEPTH (8)
    ) dut (
        .clk              (clk),
        .rst_n            (rst_n),
        .sym_data         (sym_data),
        .sym_valid        (sym_valid),
        .sym_ready        (sym_ready),
        .start            (start),
        .stop             (stop),
        .flush            (flush),
        .cfg_prescaler    (cfg_prescaler),
        .cfg_idle_level   (cfg_idle_level),
        .cfg_invert       (cfg_invert),
        .cfg_carrier_half (cfg_carrier_half),
        .cfg_carrier_mask (cfg_carrier_mask),
        .busy             (busy),
        .done             (done),
        .underrun         (underrun),
        .underrun_clr     (underrun_clr),
        .pulse_out        (pulse_out),
        .fifo_count       (fifo_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_sym(input logic last, input logic [1:0] lvl, input logic [15:0] dur);
        sym_data  = {last, lvl, dur};
        sym_valid = 1'b1;
        step();
        sym_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        step();
        step();
        checks++;
        if ({pulse_out, busy, done, underrun} !== 5'b0) begin
            errors++;
            $display("FAIL reset_outputs got pulse=%b busy=%b done=%b und=%b want 0", pulse_out, busy, done, underrun);
        end
        checks++;
        if (fifo_count !== 4'd0 || sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_fifo got count=%0d ready=%b want 0/1", fifo_count, sym_ready);
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (pulse_out !== 2'b00 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release got pulse=%b busy=%b want 00/0", pulse_out, busy);
        end
        $display("reset: count=%0d ready=%b", fifo_count, sym_ready);
    endtask

    task automatic test_start_empty();
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL start_empty got busy=%b want 0", busy);
        end
        $display("start on empty fifo: busy=%b", busy);
    endtask

    task automatic test_sequence();
        logic [1:0] exp_p;
        cfg_prescaler = 8'd3;
        push_sym(1'b0, 2'b01, 16'd2);
        push_sym(1'b1, 2'b10, 16'd0);
        checks++;
        if (fifo_count !== 4'd2) begin
            errors++;
            $display("FAIL seq_count got %0d want 2", fifo_count);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (busy !== 1'b1 || pulse_out !== 2'b01 || fifo_count !== 4'd1) begin
            errors++;
            $display("FAIL seq_load got busy=%b pulse=%b count=%0d want 1/01/1", busy, pulse_out, fifo_count);
        end
        for (int k = 1; k <= 16; k++) begin
            step();
            exp_p = (k < 12) ? 2'b01 : ((k < 16) ? 2'b10 : 2'b00);
            checks++;
            if (pulse_out !== exp_p || done !== (k == 16) || busy !== (k < 16)) begin
                errors++;
                $display("FAIL seq_cycle%0d got pulse=%b done=%b busy=%b want %b/%b/%b",
                         k, pulse_out, done, busy, exp_p, (k == 16), (k < 16));
            end
        end
        step();
        checks++;
        if (done !== 1'b0) begin
            errors++;
            $display("FAIL seq_done_width got done=%b want 0", done);
        end
        $display("sequence: two symbols sent, done pulsed, busy=%b", busy);
    endtask

    task automatic test_underrun();
        logic saw_done;
        saw_done = 1'b0;
        cfg_prescaler = 8'd0;
        push_sym(1'b0, 2'b01, 16'd1);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 1; k <= 2; k++) begin
            checks++;
            if (pulse_out !== 2'b01 || busy !== 1'b1) begin
                errors++;
                $display("FAIL underrun_active%0d got pulse=%b busy=%b want 01/1", k, pulse_out, busy);
            end
            saw_done |= done;
            step();
        end
        checks++;
        if (pulse_out !== 2'b00 || busy !== 1'b0 || underrun !== 1'b1) begin
            errors++;
            $display("FAIL underrun_end got pulse=%b busy=%b und=%b want 00/0/1", pulse_out, busy, underrun);
        end
        for (int k = 0; k < 3; k++) begin
            saw_done |= done;
            step();
        end
        checks++;
        if (underrun !== 1'b1 || saw_done !== 1'b0) begin
            errors++;
            $display("FAIL underrun_sticky got und=%b done_seen=%b want 1/0", underrun, saw_done);
        end
        underrun_clr = 1'b1;
        step();
        underrun_clr = 1'b0;
        checks++;
        if (underrun !== 1'b0) begin
            errors++;
            $display("FAIL underrun_clr got %b want 0", underrun);
        end
        $display("underrun: set then cleared, underrun=%b", underrun);
    endtask

    task automatic test_fifo_full_stop();
        for (int i = 0; i < 8; i++) push_sym(1'b0, 2'b11, 16'd3);
        checks++;
        if (fifo_count !== 4'd8 || sym_ready !== 1'b0) begin
            errors++;
            $display("FAIL full got count=%0d ready=%b want 8/0", fifo_count, sym_ready);
        end
        sym_data  = {1'b0, 2'b11, 16'd3};
        sym_valid = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (fifo_count !== 4'd8 || busy !== 1'b1 || pulse_out !== 2'b11) begin
                errors++;
                $display("FAIL full_pushpop%0d got count=%0d busy=%b pulse=%b want 8/1/11", k, fifo_count, busy, pulse_out);
            end
            step();
        end
        sym_valid = 1'b0;
        stop = 1'b1;
        step();
        stop = 1'b0;
        checks++;
        if (busy !== 1'b0 || pulse_out !== 2'b00 || done !== 1'b0 || fifo_count !== 4'd8) begin
            errors++;
            $display("FAIL stop got busy=%b pulse=%b done=%b count=%0d want 0/00/0/8", busy, pulse_out, done, fifo_count);
        end
        $display("full/stop: count=%0d retained after stop", fifo_count);
    endtask

    task automatic test_reset_mid();
        start = 1'b1;
        step();
        start = 1'b0;
        step();
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        checks++;
        if (pulse_out !== 2'b00 || busy !== 1'b0 || done !== 1'b0 || fifo_count !== 4'd0) begin
            errors++;
            $display("FAIL reset_mid got pulse=%b busy=%b done=%b count=%0d want 00/0/0/0", pulse_out, busy, done, fifo_count);
        end
        step();
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_after got done=%b busy=%b want 0/0", done, busy);
        end
        $display("reset mid-symbol: pulse=%b busy=%b", pulse_out, busy);
    endtask

    task automatic test_flush();
        push_sym(1'b0, 2'b01, 16'd1);
        push_sym(1'b0, 2'b01, 16'd1);
        sym_data  = {1'b1, 2'b10, 16'd0};
        sym_valid = 1'b1;
        flush     = 1'b1;
        step();
        sym_valid = 1'b0;
        flush     = 1'b0;
        checks++;
        if (fifo_count !== 4'd0 || sym_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush got count=%0d ready=%b want 0/1", fifo_count, sym_ready);
        end
        $display("flush with push: count=%0d", fifo_count);
    endtask

    task automatic test_invert();
        cfg_invert     = 2'b11;
        cfg_idle_level = 2'b00;
        step();
        checks++;
        if (pulse_out !== 2'b11) begin
            errors++;
            $display("FAIL invert_idle got %b want 11", pulse_out);
        end
        cfg_invert     = 2'b00;
        cfg_idle_level = 2'b01;
        step();
        checks++;
        if (pulse_out !== 2'b01) begin
            errors++;
            $display("FAIL idle_level got %b want 01", pulse_out);
        end
        cfg_idle_level = 2'b00;
        step();
        $display("invert/idle: pulse=%b", pulse_out);
    endtask

    task automatic test_carrier();
        logic exp0;
        cfg_prescaler    = 8'd0;
        cfg_carrier_half = 16'd1;
        cfg_carrier_mask = 2'b01;
        push_sym(1'b1, 2'b01, 16'd7);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 8; k++) begin
`ifdef PULSE_TX_CARRIER_EN
            exp0 = ((k / 2) % 2) == 0;
`else
            exp0 = 1'b1;
`endif
            checks++;
            if (pulse_out !== {1'b0, exp0}) begin
                errors++;
                $display("FAIL carrier%0d got %b want %b", k, pulse_out, {1'b0, exp0});
            end
            step();
        end
        checks++;
        if (done !== 1'b1 || busy !== 1'b0 || pulse_out !== 2'b00) begin
            errors++;
            $display("FAIL carrier_end got done=%b busy=%b pulse=%b want 1/0/00", done, busy, pulse_out);
        end
        $display("carrier: 8-clock symbol sent");
    endtask

    initial begin
        rst_n            = 1'b0;
        sym_data         = '0;
        sym_valid        = 1'b0;
        start            = 1'b0;
        stop             = 1'b0;
        flush            = 1'b0;
        cfg_prescaler    = 8'd0;
        cfg_idle_level   = 2'b00;
        cfg_invert       = 2'b00;
        cfg_carrier_half = 16'd0;
        cfg_carrier_mask = 2'b00;
        underrun_clr     = 1'b0;
        test_reset();
        test_start_empty();
        test_sequence();
        test_underrun();
        test_fifo_full_stop();
        test_reset_mid();
        test_flush();
        test_invert();
        test_carrier();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/multi_pulse_transmitter.md
MULTI_PULSE_TRANSMITTER -- requirements
Module: multi_pulse_transmitter

Interface
REQ-001 Parameter NUM_CH, default 2: number of independent output channels, range 1..8.
REQ-002 Parameter DUR_W, default 16: symbol duration field width, range 4..16.
REQ-003 Parameter FIFO_DEPTH, default 8: symbol FIFO entries, power of two, range 2..32.
REQ-004 Port clk  in  1: clock; the only clock; all state changes on its rising edge.
REQ-005 Port rst_n  in  1: reset; synchronous, active-low.
REQ-006 Port sym_data  in  NUM_CH+DUR_W+1: symbol {last, levels[NUM_CH-1:0], duration[DUR_W-1:0]}.
REQ-007 Ports sym_valid in 1, sym_ready out 1: symbol push handshake; a transfer occurs when both are high at a clock edge.
REQ-008 Ports start, stop, flush  in  1 each: control strobes, one-cycle pulses.
REQ-009 Port cfg_prescaler  in  8: tick period minus one, in clocks.
REQ-010 Ports cfg_idle_level, cfg_invert  in  NUM_CH each: per-channel idle level and output inversion.
REQ-011 Ports cfg_carrier_half in 16, cfg_carrier_mask in NUM_CH: carrier half-period minus one, and the channels modulated by the carrier.
REQ-012 Ports busy out 1, done out 1, underrun out 1, underrun_clr in 1.
REQ-013 Ports pulse_out out NUM_CH and fifo_count out $clog2(FIFO_DEPTH)+1.

Function
REQ-014 sym_ready SHALL equal !full, with no combinational path from start, stop or the pop side.
REQ-015 A push and a pop in the same cycle SHALL leave fifo_count unchanged, including when the FIFO is full.
REQ-016 The FSM states SHALL be IDLE and RUN.
REQ-017 IDLE->RUN SHALL occur on start when the FIFO is non-empty: the head is popped at that edge, and pulse_out reflects it from the next cycle (1-cycle latency).
REQ-018 start with an empty FIFO, or start in RUN, SHALL be ignored.
REQ-019 Each symbol SHALL occupy exactly (duration+1)*(cfg_prescaler+1) clocks; duration=0 gives one tick.
REQ-020 The prescaler SHALL reset at every symbol load.
REQ-021 At symbol expiry, a non-last symbol with the FIFO non-empty SHALL pop the next symbol at the same edge, with zero gap clocks.
REQ-022 At expiry of a symbol with last=1: go to IDLE and pulse done for one cycle.
REQ-023 At expiry of a non-last symbol with the FIFO empty: go to IDLE, set the sticky underrun flag, and do not assert done.
REQ-024 stop in RUN SHALL go to IDLE at the next edge without done; FIFO contents are retained.
REQ-025 flush SHALL empty the FIFO at the next edge; flush wins over a simultaneous push.
REQ-026 underrun_clr SHALL clear underrun; a simultaneous set wins.
REQ-027 busy SHALL be 1 exactly in RUN.
REQ-028 pulse_out[i] SHALL be registered, equal to (RUN ? level[i] : cfg_idle_level[i]) ^ cfg_invert[i].
REQ-029 cfg_* changes SHALL take effect at the next symbol load, except idle level and invert, which take effect immediately.

Reset
REQ-030 While rst_n=0 at an edge: FSM=IDLE, FIFO empty, and prescaler, duration and carrier counters all 0.
REQ-031 After reset: pulse_out=0, busy=0, done=0, underrun=0, fifo_count=0, sym_ready=1.
REQ-032 Reset SHALL be honoured mid-symbol with no completion of the symbol and no done pulse.

Configuration
REQ-033 With PULSE_TX_CARRIER_EN defined, a free-running carrier SHALL toggle every cfg_carrier_half+1 clocks while busy, and be held at 0 when not busy.
REQ-034 With PULSE_TX_CARRIER_EN defined, channels in cfg_carrier_mask SHALL output level AND carrier before inversion.
REQ-035 Without PULSE_TX_CARRIER_EN, the carrier logic SHALL be absent, the cfg_carrier_* ports SHALL be present but ignored, and outputs SHALL be unmodulated.

Structure
REQ-036 Package pulse_tx_pkg SHALL hold the FSM state encoding, the sym_data field offset functions of NUM_CH and DUR_W, and parameter range limits.
REQ-037 Sub-module pulse_tx_symbol_fifo SHALL be a synchronous first-word-fall-through FIFO providing push, pop, flush and count.

Verification
REQ-038 Prescaler=3: push {0,01,d=2} and {1,10,d=0}, then start -> ch0 high 12 clocks, then ch1 high 4 clocks, no gap, done 1 cycle, busy 0.
REQ-039 Push 1 non-last symbol (d=1, prescaler 0), then start -> 2 clocks active, then IDLE; underrun=1 until underrun_clr, done never asserted.
REQ-040 Fill FIFO to 8 -> sym_ready=0; simultaneous push+pop in RUN -> fifo_count stays 8.
REQ-041 stop mid-symbol, or rst_n=0 mid-symbol -> idle level (reset: 0) at the next edge, no done; after stop the remaining FIFO entries are retained.
REQ-042 PULSE_TX_CARRIER_EN, cfg_carrier_half=1, mask=01, ch0 level 1 -> ch0 toggles every 2 clocks and ch1 is steady; without the macro, ch0 is steady high.
REQ-043 cfg_invert=11, idle=00, FSM in IDLE -> pulse_out=11.
